// File: rtl/pio_pkg.sv
// Shared definitions for the debounced input PIO: register map and counter sizing.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RAW      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;

  // Width of a counter that must hold 0..cycles; never narrower than one bit so
  // the bypass configuration still elaborates cleanly.
  function automatic int CNT_W(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pio_debounce_channel.sv
// One input channel: multi-flop synchroniser followed by a stable-count debouncer.
module pio_debounce_channel
  import pio_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pad,
  output logic raw,
  output logic deb
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous pad through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{RESET_BIT}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
  end

  assign raw = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign deb = raw;
    end else begin : g_deb
      localparam int             CW       = CNT_W(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          deb_q;

      // Accept a new level only after it has differed from the current one for
      // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt   <= '0;
          deb_q <= RESET_BIT;
        end else if (raw == deb_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          deb_q <= raw;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign deb = deb_q;
    end
  endgenerate

endmodule

// File: rtl/avalon_pio_debounced_in.sv
// Avalon-MM input PIO with per-channel debouncing, edge capture and masked IRQ.
module avalon_pio_debounced_in
  import pio_pkg::*;
#(
  parameter int               WIDTH           = 2,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 1000,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] raw, deb, deb_d;
  logic [WIDTH-1:0] irq_mask, edge_cap, rise_en, fall_en;
  logic [WIDTH-1:0] rise, fall, w1c, rd_sel;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      pio_debounce_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_BIT       (RESET_LEVEL[i])
      ) u_ch (
        .clk     (clk),
        .reset_n (reset_n),
        .pad     (in_port[i]),
        .raw     (raw[i]),
        .deb     (deb[i])
      );
    end
  endgenerate

  // Edge qualification and the write-1-to-clear vector for this cycle.
  always_comb begin
    rise = deb & ~deb_d & rise_en;
    fall = ~deb & deb_d & fall_en;
    w1c  = '0;
    if (wr_en && address == ADDR_EDGE_CAP) w1c = writedata[WIDTH-1:0];
  end

  // Control registers and edge capture; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d    <= RESET_LEVEL;
      irq_mask <= '0;
      edge_cap <= '0;
      rise_en  <= '1;
      fall_en  <= '0;
    end else begin
      deb_d    <= deb;
      edge_cap <= (edge_cap & ~w1c) | rise | fall;
      if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
      if (wr_en && address == ADDR_RISE_EN)  rise_en  <= writedata[WIDTH-1:0];
      if (wr_en && address == ADDR_FALL_EN)  fall_en  <= writedata[WIDTH-1:0];
    end
  end

  // Read mux, zero-extended to the bus width; unmapped addresses read 0.
  always_comb begin
    rd_sel = '0;
    case (address)
      ADDR_DATA:     rd_sel = deb;
      ADDR_RAW:      rd_sel = raw;
      ADDR_IRQ_MASK: rd_sel = irq_mask;
      ADDR_EDGE_CAP: rd_sel = edge_cap;
      ADDR_RISE_EN:  rd_sel = rise_en;
      ADDR_FALL_EN:  rd_sel = fall_en;
      default:       rd_sel = '0;
    endcase
    rd_next              = '0;
    rd_next[WIDTH-1:0]   = rd_sel;
  end

  // Read data is registered every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(edge_cap & irq_mask);

endmodule
